// File: rtl/hit_event_reporter.sv
// hit_event_reporter
//   Hardware-to-CPU event path. Watches the per-frame hit and health signals
//   and packs each hit into a 16-bit event word. The words are buffered in a
//   FIFO. The CPU drains the FIFO over a four-phase req/ack handshake.
//
// Ports
//   Clk, Reset_n        system clock, asynchronous active-low reset
//   frame_vs            VGA vsync; its rising edge marks a frame boundary
//   ryu_hit, akuma_hit  per-frame hit levels
//   ryu_health,
//   akuma_health        health bar values, latched at the frame boundary
//   clear               synchronous flush of FIFO, overflow and frame counter
//   rd_req / rd_ack     four-phase read handshake (CPU drives req)
//   rd_data             event word, valid while rd_ack=1, held afterwards
//   evt_count           FIFO occupancy, 0..DEPTH
//   overflow            sticky flag: an event was dropped on a full FIFO
//
// Event word: [15:14] type (01 Ryu hit, 10 Akuma hit, 11 KO, 00 empty read),
//             [13:8] frame number [5:0], [7:0] victim health.

module hit_event_reporter #(
    parameter int DEPTH   = 16,
    parameter int FRAME_W = 8
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_vs,
    input  logic                     ryu_hit,
    input  logic                     akuma_hit,
    input  logic [7:0]               ryu_health,
    input  logic [7:0]               akuma_health,
    input  logic                     clear,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic [15:0]              rd_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_RYU, W_AKUMA} wr_state_t;
    typedef enum logic       {R_IDLE, R_WAIT}         rd_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               vs_meta_q,  vs_meta_d;
    logic               vs_sync_q,  vs_sync_d;
    logic               vs_prev_q,  vs_prev_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    logic               cap_akuma_hit_q, cap_akuma_hit_d;
    logic [7:0]         cap_ryu_hp_q,    cap_ryu_hp_d;
    logic [7:0]         cap_akuma_hp_q,  cap_akuma_hp_d;
    logic [5:0]         cap_frame_q,     cap_frame_d;

    wr_state_t          wr_state_q, wr_state_d;
    rd_state_t          rd_state_q, rd_state_d;

    logic [15:0]        mem_q [DEPTH];
    logic [15:0]        mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q,  count_d;
    logic               overflow_q, overflow_d;

    logic               rd_ack_q,  rd_ack_d;
    logic [15:0]        rd_data_q, rd_data_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               frame_tick;
    logic [FRAME_W-1:0] frame_inc;
    logic               push, pop;
    logic               push_ok, pop_ok;
    logic [15:0]        push_word;
    logic               fifo_full, fifo_empty;
    logic [15:0]        ryu_word, akuma_word;

    // A zero victim health turns the hit into a KO event.
    function automatic logic [15:0] make_word(input logic [1:0] kind,
                                              input logic [5:0] frm,
                                              input logic [7:0] hp);
        logic [1:0] t;
        t = (hp == 8'd0) ? 2'b11 : kind;
        return {t, frm, hp};
    endfunction

    assign frame_tick = vs_sync_q & ~vs_prev_q;
    assign frame_inc  = frame_cnt_q + FRAME_W'(1);
    assign ryu_word   = make_word(2'b01, cap_frame_q, cap_ryu_hp_q);
    assign akuma_word = make_word(2'b10, cap_frame_q, cap_akuma_hp_q);
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // ------------------------------------------------------------------
    // Frame synchronizer, frame counter and capture registers
    // ------------------------------------------------------------------
    always_comb begin
        vs_meta_d       = frame_vs;
        vs_sync_d       = vs_meta_q;
        vs_prev_d       = vs_sync_q;
        frame_cnt_d     = frame_cnt_q;
        cap_akuma_hit_d = cap_akuma_hit_q;
        cap_ryu_hp_d    = cap_ryu_hp_q;
        cap_akuma_hp_d  = cap_akuma_hp_q;
        cap_frame_d     = cap_frame_q;

        if (frame_tick) begin
            frame_cnt_d     = frame_inc;
            cap_akuma_hit_d = akuma_hit;
            cap_ryu_hp_d    = ryu_health;
            cap_akuma_hp_d  = akuma_health;
            // Events carry the number of the frame just started, so frame 1
            // is the first boundary after reset or clear.
            cap_frame_d     = frame_inc[5:0];
        end
        if (clear) begin
            frame_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Writer FSM: one push per cycle, Ryu before Akuma on a double hit
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d = wr_state_q;
        push       = 1'b0;
        push_word  = '0;
        case (wr_state_q)
            W_IDLE: begin
                if (frame_tick) begin
                    if (ryu_hit)        wr_state_d = W_RYU;
                    else if (akuma_hit) wr_state_d = W_AKUMA;
                end
            end
            W_RYU: begin
                push       = 1'b1;
                push_word  = ryu_word;
                wr_state_d = cap_akuma_hit_q ? W_AKUMA : W_IDLE;
            end
            W_AKUMA: begin
                push       = 1'b1;
                push_word  = akuma_word;
                wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        // Flushing also abandons any capture still waiting to be pushed.
        if (clear) wr_state_d = W_IDLE;
    end

    // ------------------------------------------------------------------
    // Reader FSM: one pop per handshake, data latched at request time
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ack_d   = rd_ack_q;
        rd_data_d  = rd_data_q;
        pop        = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_req) begin
                    rd_state_d = R_WAIT;
                    rd_ack_d   = 1'b1;
                    rd_data_d  = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
                    pop        = ~fifo_empty;
                end
            end
            R_WAIT: begin
                if (!rd_req) begin
                    rd_state_d = R_IDLE;
                    rd_ack_d   = 1'b0;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                rd_ack_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    // A push on a full FIFO is dropped even when a pop frees a slot in the
    // same cycle; clear overrides both push and pop.
    assign push_ok = push & ~fifo_full & ~clear;
    assign pop_ok  = pop & ~clear;

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = push_word;

        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(pop_ok);
        count_d    = count_q + CW'(push_ok) - CW'(pop_ok);
        overflow_d = overflow_q | (push & fifo_full);

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_meta_q       <= 1'b0;
            vs_sync_q       <= 1'b0;
            vs_prev_q       <= 1'b0;
            frame_cnt_q     <= '0;
            cap_akuma_hit_q <= 1'b0;
            cap_ryu_hp_q    <= '0;
            cap_akuma_hp_q  <= '0;
            cap_frame_q     <= '0;
            wr_state_q      <= W_IDLE;
            rd_state_q      <= R_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            overflow_q      <= 1'b0;
            rd_ack_q        <= 1'b0;
            rd_data_q       <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            vs_meta_q       <= vs_meta_d;
            vs_sync_q       <= vs_sync_d;
            vs_prev_q       <= vs_prev_d;
            frame_cnt_q     <= frame_cnt_d;
            cap_akuma_hit_q <= cap_akuma_hit_d;
            cap_ryu_hp_q    <= cap_ryu_hp_d;
            cap_akuma_hp_q  <= cap_akuma_hp_d;
            cap_frame_q     <= cap_frame_d;
            wr_state_q      <= wr_state_d;
            rd_state_q      <= rd_state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            overflow_q      <= overflow_d;
            rd_ack_q        <= rd_ack_d;
            rd_data_q       <= rd_data_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign evt_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_hit_event_reporter.sv
module tb_hit_event_reporter;

    localparam int DEPTH = 16;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_vs, ryu_hit, akuma_hit, clear, rd_req;
    logic [7:0]  ryu_health, akuma_health;
    logic        rd_ack, overflow;
    logic [15:0] rd_data;
    logic [4:0]  evt_count;

    hit_event_reporter #(.DEPTH(DEPTH), .FRAME_W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs),
        .ryu_hit(ryu_hit), .akuma_hit(akuma_hit),
        .ryu_health(ryu_health), .akuma_health(akuma_health),
        .clear(clear), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
        .evt_count(evt_count), .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of event words, frame number, sticky overflow.
    logic [15:0] mq[$];
    int          mframe = 0;
    bit          movf   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic void model_push(input int kind, input int hp);
        int t;
        t = (hp == 0) ? 3 : kind;
        if (mq.size() == DEPTH) movf = 1'b1;
        else mq.push_back(16'(t * 16384 + (mframe % 64) * 256 + hp));
    endfunction

    function automatic void model_frame(input bit rh, input bit ah, input int rhp, input int ahp);
        mframe = (mframe + 1) % 256;
        if (rh) model_push(1, rhp);
        if (ah) model_push(2, ahp);
    endfunction

    function automatic void model_clear();
        mq.delete();
        mframe = 0;
        movf   = 1'b0;
    endfunction

    task automatic do_frame(input logic rh, input logic ah, input logic [7:0] rhp, input logic [7:0] ahp);
        ryu_hit = rh; akuma_hit = ah; ryu_health = rhp; akuma_health = ahp;
        frame_vs = 1'b1;
        model_frame(rh, ah, int'(rhp), int'(ahp));
        repeat (3) step();
        frame_vs = 1'b0;
        repeat (5) step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
    endtask

    task automatic read_hs(input string nm, output logic [15:0] got);
        logic [15:0] exp;
        bit          seen;
        exp  = (mq.size() > 0) ? mq.pop_front() : 16'h0000;
        seen = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (rd_ack) seen = 1'b1;
        end
        chk({nm, "_ack"}, 32'(seen), 32'd1);
        chk({nm, "_data"}, 32'(rd_data), 32'(exp));
        got = rd_data;
        rd_req = 1'b0;
        step();
        chk({nm, "_ackdrop"}, 32'(rd_ack), 32'd0);
    endtask

    typedef struct {
        logic        rh, ah;
        logic [7:0]  rhp, ahp;
        int          n;
        logic [15:0] w0, w1;
    } vec_t;

    vec_t        tbl[5];
    logic [15:0] g;
    int          r;
    logic        rh_r, ah_r;
    logic [7:0]  rhp_r, ahp_r;

    initial begin
        // Frames 4..8 (frame 3 is the last directed frame before the table).
        tbl[0] = '{1'b1, 1'b0, 8'd100, 8'd0,   1, 16'h4464, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 8'd7,   8'h20,  1, 16'h8520, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 8'd5,   8'd5,   0, 16'h0000, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 8'd0,   8'd9,   1, 16'hC700, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 8'd1,   8'd255, 2, 16'h4801, 16'h88FF};

        Reset_n = 1'b0; frame_vs = 1'b0; ryu_hit = 1'b0; akuma_hit = 1'b0;
        ryu_health = 8'd0; akuma_health = 8'd0; clear = 1'b0; rd_req = 1'b0;
        repeat (3) step();
        chk("rst_ack", 32'(rd_ack), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_cnt", 32'(evt_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        Reset_n = 1'b1;
        repeat (2) step();

        // Frame 1: Ryu hit, health 90; check push latency.
        ryu_hit = 1'b1; ryu_health = 8'd90; frame_vs = 1'b1;
        model_frame(1'b1, 1'b0, 90, 0);
        repeat (3) step();
        chk("lat_cnt_early", 32'(evt_count), 32'd0);
        step();
        chk("lat_cnt", 32'(evt_count), 32'd1);
        frame_vs = 1'b0; ryu_hit = 1'b0;
        repeat (4) step();
        read_hs("f1", g);
        chk("f1_word", 32'(g), 32'h415A);
        chk("f1_cnt", 32'(evt_count), 32'd0);

        // Frame 2 quiet, frame 3 double hit with Akuma KO.
        do_frame(1'b0, 1'b0, 8'd0, 8'd0);
        chk("f2_cnt", 32'(evt_count), 32'd0);
        do_frame(1'b1, 1'b1, 8'd50, 8'd0);
        chk("f3_cnt", 32'(evt_count), 32'd2);
        read_hs("f3a", g);
        chk("f3a_word", 32'(g), 32'h4332);
        read_hs("f3b", g);
        chk("f3b_word", 32'(g), 32'hC300);

        // Empty read.
        read_hs("empty", g);
        chk("empty_word", 32'(g), 32'h0000);
        chk("empty_cnt", 32'(evt_count), 32'd0);

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            do_frame(tbl[i].rh, tbl[i].ah, tbl[i].rhp, tbl[i].ahp);
            chk("tbl_cnt", 32'(evt_count), 32'(tbl[i].n));
            if (tbl[i].n > 0) begin
                read_hs("tbl_rd0", g);
                chk("tbl_w0", 32'(g), 32'(tbl[i].w0));
            end
            if (tbl[i].n > 1) begin
                read_hs("tbl_rd1", g);
                chk("tbl_w1", 32'(g), 32'(tbl[i].w1));
            end
        end

        // Overflow: 17 hit frames, no reads.
        do_clear();
        for (int i = 1; i <= 17; i++) do_frame(1'b1, 1'b0, 8'(i), 8'd0);
        chk("ovf_cnt", 32'(evt_count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            read_hs("ovf_rd", g);
            chk("ovf_word", 32'(g), 32'(16'h4000 | 16'(i * 256 + i)));
        end
        read_hs("ovf_tail", g);
        chk("ovf_tail_word", 32'(g), 32'h0000);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Clear while full and mid-handshake.
        do_clear();
        for (int i = 1; i <= 17; i++) do_frame(1'b0, 1'b1, 8'(i + 3), 8'(i + 3));
        rd_req = 1'b1;
        step();
        chk("clr_ack", 32'(rd_ack), 32'd1);
        chk("clr_data", 32'(rd_data), 32'(mq[0]));
        g = mq.pop_front();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        chk("clr_cnt", 32'(evt_count), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_ack_held", 32'(rd_ack), 32'd1);
        chk("clr_data_held", 32'(rd_data), 32'(g));
        rd_req = 1'b0;
        step();
        chk("clr_ackdrop", 32'(rd_ack), 32'd0);

        // Randomized mix against the model.
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                do_clear();
            end else if (r < 45) begin
                read_hs("rnd_rd", g);
            end else begin
                rh_r  = 1'($urandom_range(0, 1));
                ah_r  = 1'($urandom_range(0, 1));
                rhp_r = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                ahp_r = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                do_frame(rh_r, ah_r, rhp_r, ahp_r);
            end
            chk("rnd_cnt", 32'(evt_count), 32'(mq.size()));
            chk("rnd_ovf", 32'(overflow), 32'(movf));
        end

        // Reset mid-handshake with a full, overflowed FIFO.
        do_clear();
        for (int i = 1; i <= 17; i++) do_frame(1'b1, 1'b0, 8'd60, 8'd0);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        rd_req = 1'b1;
        step();
        chk("pre_rst_ack", 32'(rd_ack), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_ack", 32'(rd_ack), 32'd0);
        chk("async_cnt", 32'(evt_count), 32'd0);
        chk("async_ovf", 32'(overflow), 32'd0);
        rd_req = 1'b0;
        step();
        Reset_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
